sync_updown_counter: RTL and testbench

Parametrised synchronous up/down counter with programmable modulus, parallel load, clock enable and terminal-count reporting. It is the general-purpose successor to the fixed 4-bit free-running up counter. It covers dividers, event counters and timeout timers anywhere in the design. It is clocked on the rising edge only, and all state changes are synchronous except reset.

---
 rtl/counter_pkg.sv | 19 +
 rtl/sync_updown_counter.sv | 128 ++++++++++++
 tb/tb_sync_updown_counter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the counter and timer family.
//   DIR_UP / DIR_DOWN : encodings of the up_dn direction input.
//   clamp_load()      : limits a parallel-load value to the top of a counter's
//                       range, so a load can never place a counter out of range.
// -----------------------------------------------------------------------------
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Returns value when it lies within 0..max, otherwise max.
  function automatic logic [31:0] clamp_load(input logic [31:0] value,
                                             input logic [31:0] max);
    return (value > max) ? max : value;
  endfunction

endpackage

// File: rtl/sync_updown_counter.sv
// -----------------------------------------------------------------------------
// sync_updown_counter
// Parametrised up/down counter with programmable modulus, parallel load,
// clock enable and terminal-count reporting. Counts over 0..MAX_COUNT and
// either wraps (SATURATE=0) or holds (SATURATE=1) at the range ends.
//
// Parameters
//   WIDTH      counter width, 2..32
//   MAX_COUNT  top of the count range, 1..2**WIDTH-1
//   SATURATE   0 = wrap at range ends, 1 = hold at range ends
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous reset, active low
//   clear     in   synchronous clear of count, wrap and ovf (highest priority)
//   load      in   synchronous load of load_val (clamped to MAX_COUNT)
//   load_val  in   value to load
//   en        in   count enable
//   up_dn     in   direction, 1 = up, 0 = down
//   count     out  registered count
//   tc        out  terminal count (combinational)
//   wrap      out  registered one-cycle pulse after a wrapping edge
//   ovf       out  registered sticky overflow/underflow flag
// -----------------------------------------------------------------------------
module sync_updown_counter
  import counter_pkg::*;
#(
  parameter int              WIDTH     = 4,
  parameter longint unsigned MAX_COUNT = (64'd1 << WIDTH) - 64'd1,
  parameter bit              SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_dn,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  // Reject illegal configurations while elaborating rather than letting
  // a truncated MAX_COUNT silently produce a different modulus.
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $fatal(1, "sync_updown_counter: WIDTH=%0d outside 2..32", WIDTH);
  end
  if (MAX_COUNT < 64'd1 || MAX_COUNT > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
    $fatal(1, "sync_updown_counter: MAX_COUNT=%0d illegal for WIDTH=%0d",
           MAX_COUNT, WIDTH);
  end

  localparam logic [WIDTH-1:0] MAX_V = MAX_COUNT[WIDTH-1:0];

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_ovf;

  logic             w_up;
  logic             w_dn;
  logic             w_at_max;
  logic             w_at_zero;
  logic [WIDTH-1:0] w_load_val;

  assign w_up      = (up_dn == DIR_UP);
  assign w_dn      = (up_dn == DIR_DOWN);
  assign w_at_max  = (r_count == MAX_V);
  assign w_at_zero = (r_count == '0);

  // Result never exceeds MAX_V, so narrowing back to WIDTH bits is lossless.
  assign w_load_val = WIDTH'(clamp_load(32'(load_val), 32'(MAX_V)));

  // tc depends only on the present count and control inputs; it is valid
  // during reset too, since the count is forced to zero there.
  assign tc = en & ((w_up & w_at_max) | (w_dn & w_at_zero));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (clear) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (load) begin
      // A load cycle never counts; ovf keeps its history.
      r_count <= w_load_val;
      r_wrap  <= 1'b0;
    end else if (en) begin
      if (w_up) begin
        if (!w_at_max) begin
          r_count <= r_count + WIDTH'(1);
          r_wrap  <= 1'b0;
        end else if (SATURATE) begin
          r_wrap  <= 1'b0;
          r_ovf   <= 1'b1;
        end else begin
          r_count <= '0;
          r_wrap  <= 1'b1;
          r_ovf   <= 1'b1;
        end
      end else begin
        if (!w_at_zero) begin
          r_count <= r_count - WIDTH'(1);
          r_wrap  <= 1'b0;
        end else if (SATURATE) begin
          r_wrap  <= 1'b0;
          r_ovf   <= 1'b1;
        end else begin
          // Wrap downward to the programmed top, not to all-ones.
          r_count <= MAX_V;
          r_wrap  <= 1'b1;
          r_ovf   <= 1'b1;
        end
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign count = r_count;
  assign wrap  = r_wrap;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_sync_updown_counter.sv
module tb_sync_updown_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic       en = 1'b0;
  logic       up_dn = 1'b1;

  logic [3:0] a_count, b_count, c_count;
  logic       a_tc, b_tc, c_tc;
  logic       a_wrap, b_wrap, c_wrap;
  logic       a_ovf, b_ovf, c_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // A: modulo-10 wrapping, B: modulo-10 saturating, C: default 4-bit.
  sync_updown_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b0)) u_a (
    .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
    .en(en), .up_dn(up_dn), .count(a_count), .tc(a_tc), .wrap(a_wrap), .ovf(a_ovf));

  sync_updown_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b1)) u_b (
    .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
    .en(en), .up_dn(up_dn), .count(b_count), .tc(b_tc), .wrap(b_wrap), .ovf(b_ovf));

  sync_updown_counter #(.WIDTH(4)) u_c (
    .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
    .en(en), .up_dn(up_dn), .count(c_count), .tc(c_tc), .wrap(c_wrap), .ovf(c_ovf));

  // Advance one rising edge; returns 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1; load = 1'b0; en = 1'b0;
    step();
    clear = 1'b0;
  endtask

  task automatic do_load(input logic [3:0] v);
    load = 1'b1; load_val = v; en = 1'b0;
    step();
    load = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0; en = 1'b1; up_dn = 1'b0;
    #1;
    n_cmp++; if (a_count !== 4'd0) begin n_bad++; $display("FAIL reset_count got=%0d exp=0", a_count); end
    n_cmp++; if (a_wrap !== 1'b0) begin n_bad++; $display("FAIL reset_wrap got=%b exp=0", a_wrap); end
    n_cmp++; if (a_ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got=%b exp=0", a_ovf); end
    n_cmp++; if (a_tc !== 1'b1) begin n_bad++; $display("FAIL reset_tc_down got=%b exp=1", a_tc); end
    step();
    rst = 1'b1; up_dn = 1'b1; en = 1'b1;
    for (int i = 0; i < 5; i++) step();
    n_cmp++; if (a_count !== 4'd5) begin n_bad++; $display("FAIL precount got=%0d exp=5", a_count); end
    #3 rst = 1'b0;
    #1;
    n_cmp++; if (a_count !== 4'd0) begin n_bad++; $display("FAIL midreset_count got=%0d exp=0", a_count); end
    n_cmp++; if (a_wrap !== 1'b0 || a_ovf !== 1'b0) begin n_bad++; $display("FAIL midreset_flags got=%b%b exp=00", a_wrap, a_ovf); end
    rst = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      n_cmp++; if (a_count !== 4'(i)) begin n_bad++; $display("FAIL release_seq%0d got=%0d exp=%0d", i, a_count, i); end
    end
  endtask

  task automatic test_wrap();
    do_clear();
    en = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 9; i++) step();
    n_cmp++; if (a_count !== 4'd9) begin n_bad++; $display("FAIL wrap_at9 got=%0d exp=9", a_count); end
    n_cmp++; if (a_tc !== 1'b1) begin n_bad++; $display("FAIL wrap_tc got=%b exp=1", a_tc); end
    n_cmp++; if (a_ovf !== 1'b0) begin n_bad++; $display("FAIL wrap_ovf_pre got=%b exp=0", a_ovf); end
    step();
    n_cmp++; if (a_count !== 4'd0) begin n_bad++; $display("FAIL wrap_to0 got=%0d exp=0", a_count); end
    n_cmp++; if (a_wrap !== 1'b1 || a_ovf !== 1'b1) begin n_bad++; $display("FAIL wrap_flags got=%b%b exp=11", a_wrap, a_ovf); end
    step();
    n_cmp++; if (a_count !== 4'd1 || a_wrap !== 1'b0 || a_ovf !== 1'b1) begin n_bad++; $display("FAIL wrap_after got=%0d/%b/%b exp=1/0/1", a_count, a_wrap, a_ovf); end
    do_clear();
    en = 1'b1; up_dn = 1'b0;
    step();
    n_cmp++; if (a_count !== 4'd9 || a_wrap !== 1'b1 || a_ovf !== 1'b1) begin n_bad++; $display("FAIL down_wrap got=%0d/%b/%b exp=9/1/1", a_count, a_wrap, a_ovf); end
  endtask

  task automatic test_saturate();
    int seen_wrap;
    seen_wrap = 0;
    do_clear();
    en = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (b_wrap) seen_wrap++;
    end
    n_cmp++; if (b_count !== 4'd9) begin n_bad++; $display("FAIL sat_up got=%0d exp=9", b_count); end
    n_cmp++; if (seen_wrap !== 0) begin n_bad++; $display("FAIL sat_nowrap got=%0d exp=0", seen_wrap); end
    n_cmp++; if (b_ovf !== 1'b1) begin n_bad++; $display("FAIL sat_ovf got=%b exp=1", b_ovf); end
    do_clear();
    en = 1'b1; up_dn = 1'b0;
    step(); step();
    n_cmp++; if (b_count !== 4'd0 || b_wrap !== 1'b0 || b_ovf !== 1'b1) begin n_bad++; $display("FAIL sat_down got=%0d/%b/%b exp=0/0/1", b_count, b_wrap, b_ovf); end
  endtask

  task automatic test_priority();
    do_load(4'd9);
    en = 1'b1; up_dn = 1'b1;
    step();
    n_cmp++; if (a_ovf !== 1'b1) begin n_bad++; $display("FAIL prio_setup_ovf got=%b exp=1", a_ovf); end
    clear = 1'b1; load = 1'b1; load_val = 4'd4; en = 1'b1;
    step();
    n_cmp++; if (a_count !== 4'd0 || a_ovf !== 1'b0 || a_wrap !== 1'b0) begin n_bad++; $display("FAIL prio_clear got=%0d/%b/%b exp=0/0/0", a_count, a_ovf, a_wrap); end
    clear = 1'b0; load = 1'b1; load_val = 4'd13; en = 1'b1; up_dn = 1'b1;
    step();
    load = 1'b0;
    n_cmp++; if (a_count !== 4'd9) begin n_bad++; $display("FAIL prio_clamp got=%0d exp=9", a_count); end
    n_cmp++; if (a_wrap !== 1'b0 || a_ovf !== 1'b0) begin n_bad++; $display("FAIL prio_loadflags got=%b%b exp=00", a_wrap, a_ovf); end
  endtask

  task automatic test_enable_dir();
    logic [3:0] exp_seq [4];
    exp_seq[0] = 4'd4; exp_seq[1] = 4'd4; exp_seq[2] = 4'd5; exp_seq[3] = 4'd5;
    do_load(4'd3);
    up_dn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      en = (i % 2 == 0);
      step();
      n_cmp++; if (a_count !== exp_seq[i]) begin n_bad++; $display("FAIL en_toggle%0d got=%0d exp=%0d", i, a_count, exp_seq[i]); end
    end
    do_load(4'd7);
    en = 1'b1; up_dn = 1'b0;
    step();
    n_cmp++; if (a_count !== 4'd6) begin n_bad++; $display("FAIL dir_flip got=%0d exp=6", a_count); end
    do_load(4'd9);
    en = 1'b0; up_dn = 1'b1;
    #1;
    n_cmp++; if (a_tc !== 1'b0) begin n_bad++; $display("FAIL tc_en0 got=%b exp=0", a_tc); end
    en = 1'b1;
    #1;
    n_cmp++; if (a_tc !== 1'b1) begin n_bad++; $display("FAIL tc_en1 got=%b exp=1", a_tc); end
    up_dn = 1'b0;
    #1;
    n_cmp++; if (a_tc !== 1'b0) begin n_bad++; $display("FAIL tc_dn_at9 got=%b exp=0", a_tc); end
    en = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_load(4'd9);
    en = 1'b1; up_dn = 1'b1;
    step();
    n_cmp++; if (a_count !== 4'd0 || a_wrap !== 1'b1) begin n_bad++; $display("FAIL b2b_first got=%0d/%b exp=0/1", a_count, a_wrap); end
    up_dn = 1'b0;
    step();
    n_cmp++; if (a_count !== 4'd9 || a_wrap !== 1'b1) begin n_bad++; $display("FAIL b2b_second got=%0d/%b exp=9/1", a_count, a_wrap); end
    en = 1'b0;
    step();
    n_cmp++; if (a_count !== 4'd9 || a_wrap !== 1'b0 || a_ovf !== 1'b1) begin n_bad++; $display("FAIL b2b_hold got=%0d/%b/%b exp=9/0/1", a_count, a_wrap, a_ovf); end
  endtask

  task automatic test_default();
    int wraps;
    wraps = 0;
    do_clear();
    en = 1'b1; up_dn = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (c_wrap) wraps++;
      n_cmp++; if (c_count !== 4'(i % 16)) begin n_bad++; $display("FAIL legacy_seq%0d got=%0d exp=%0d", i, c_count, i % 16); end
    end
    n_cmp++; if (wraps !== 1 || c_wrap !== 1'b1) begin n_bad++; $display("FAIL legacy_wrap got=%0d/%b exp=1/1", wraps, c_wrap); end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_saturate();
    test_priority();
    test_enable_dir();
    test_back_to_back();
    test_default();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
